// File: rtl/rectangle128_pkg.sv
// Shared widths, key-address map and controller state encoding for the RECTANGLE-128 stream front-end.
package rectangle128_pkg;

    localparam int unsigned BLOCK_W    = 64;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned KEY_ADDR_W = 2;
    localparam int unsigned STATE_W    = 3;

    localparam logic [KEY_ADDR_W-1:0] KEY0_HI = 2'd0;
    localparam logic [KEY_ADDR_W-1:0] KEY0_LO = 2'd1;
    localparam logic [KEY_ADDR_W-1:0] KEY1_HI = 2'd2;
    localparam logic [KEY_ADDR_W-1:0] KEY1_LO = 2'd3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD_LO = 3'd1;
    localparam state_t ST_RUN     = 3'd2;
    localparam state_t ST_OUT_HI  = 3'd3;
    localparam state_t ST_OUT_LO  = 3'd4;

endpackage

// File: rtl/rectangle128_out_ser.sv
// Captures the 64-bit cipher result and presents it as high word then low word on a valid/ready stream.
module rectangle128_out_ser
    import rectangle128_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [BLOCK_W-1:0] data_i,
    input  logic               ready_i,
    output logic [WORD_W-1:0]  data_o,
    output logic               valid_o,
    output logic               hi_ack_c_o,
    output logic               done_c_o
);

    logic [WORD_W-1:0] data_q, data_d;
    logic [WORD_W-1:0] lo_q, lo_d;
    logic              valid_q, valid_d;
    logic              phase_lo_q, phase_lo_d;
    logic              take_c;

    assign take_c     = valid_q && ready_i;
    assign hi_ack_c_o = take_c && !phase_lo_q;
    assign done_c_o   = take_c && phase_lo_q;

    // The high word goes straight to the output register; the low word waits in lo_q.
    always_comb begin
        data_d     = data_q;
        lo_d       = lo_q;
        valid_d    = valid_q;
        phase_lo_d = phase_lo_q;
        if (load_i) begin
            data_d     = data_i[BLOCK_W-1:WORD_W];
            lo_d       = data_i[WORD_W-1:0];
            valid_d    = 1'b1;
            phase_lo_d = 1'b0;
        end else if (hi_ack_c_o) begin
            data_d     = lo_q;
            phase_lo_d = 1'b1;
        end else if (done_c_o) begin
            valid_d    = 1'b0;
            phase_lo_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q     <= '0;
            lo_q       <= '0;
            valid_q    <= 1'b0;
            phase_lo_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            lo_q       <= lo_d;
            valid_q    <= valid_d;
            phase_lo_q <= phase_lo_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/rectangle128_stream_ctrl.sv
// Stream front-end for the RECTANGLE-128 core: packs input/key words, runs the core, serializes the result.
// Optional RUN watchdog enabled by defining RECT128_TIMEOUT_EN.
module rectangle128_stream_ctrl
    import rectangle128_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [WORD_W-1:0]     InData,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic                  InMode,
    input  logic [WORD_W-1:0]     KeyData,
    input  logic [KEY_ADDR_W-1:0] KeyAddr,
    input  logic                  KeyWE,
    output logic                  KeyBusy,
    output logic [WORD_W-1:0]     OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic                  Enable,
    output logic                  Encrypt,
    output logic [BLOCK_W-1:0]    plainText,
    output logic [BLOCK_W-1:0]    key0,
    output logic [BLOCK_W-1:0]    key1,
    input  logic [BLOCK_W-1:0]    cipherText,
    input  logic                  cipherReady,
    output logic [CNT_W-1:0]      BlockCnt,
    output logic                  TimeoutErr
);

    state_t             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               enable_q, enable_d;
    logic               encrypt_q, encrypt_d;
    logic               busy_q, busy_d;
    logic [BLOCK_W-1:0] pt_q, pt_d;
    logic [BLOCK_W-1:0] key0_q, key0_d;
    logic [BLOCK_W-1:0] key1_q, key1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_take_c;
    logic               ser_load_c;
    logic               ser_hi_ack_c;
    logic               ser_done_c;

`ifdef RECT128_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_err_q, timeout_err_d;
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

    assign in_take_c = InValid && in_ready_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        pt_d       = pt_q;
        encrypt_d  = encrypt_q;
        key0_d     = key0_q;
        key1_d     = key1_q;
        cnt_d      = cnt_q;
        ser_load_c = 1'b0;
`ifdef RECT128_TIMEOUT_EN
        wdog_d        = wdog_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (KeyWE) begin
                    case (KeyAddr)
                        KEY0_HI: key0_d[BLOCK_W-1:WORD_W] = KeyData;
                        KEY0_LO: key0_d[WORD_W-1:0]       = KeyData;
                        KEY1_HI: key1_d[BLOCK_W-1:WORD_W] = KeyData;
                        KEY1_LO: key1_d[WORD_W-1:0]       = KeyData;
                    endcase
                end
                if (in_take_c) begin
                    pt_d[BLOCK_W-1:WORD_W] = InData;
                    encrypt_d              = InMode;
                    state_d                = ST_LOAD_LO;
                end
            end
            ST_LOAD_LO: begin
                if (in_take_c) begin
                    pt_d[WORD_W-1:0] = InData;
                    state_d          = ST_RUN;
`ifdef RECT128_TIMEOUT_EN
                    wdog_d = '0;
`endif
                end
            end
            ST_RUN: begin
                if (cipherReady) begin
                    ser_load_c = 1'b1;
                    state_d    = ST_OUT_HI;
                end
`ifdef RECT128_TIMEOUT_EN
                else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
`endif
            end
            ST_OUT_HI: begin
                if (ser_hi_ack_c) begin
                    state_d = ST_OUT_LO;
                end
            end
            ST_OUT_LO: begin
                if (ser_done_c) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake/status flags follow the next state so they are valid in the cycle they apply to.
        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD_LO);
        enable_d   = (state_d == ST_RUN);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            in_ready_q <= 1'b1;
            enable_q   <= 1'b0;
            encrypt_q  <= 1'b0;
            busy_q     <= 1'b0;
            pt_q       <= '0;
            key0_q     <= '0;
            key1_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            enable_q   <= enable_d;
            encrypt_q  <= encrypt_d;
            busy_q     <= busy_d;
            pt_q       <= pt_d;
            key0_q     <= key0_d;
            key1_q     <= key1_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef RECT128_TIMEOUT_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign TimeoutErr = timeout_err_q;
`else
    assign TimeoutErr = 1'b0;
`endif

    rectangle128_out_ser u_out_ser (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .load_i     (ser_load_c),
        .data_i     (cipherText),
        .ready_i    (OutReady),
        .data_o     (OutData),
        .valid_o    (OutValid),
        .hi_ack_c_o (ser_hi_ack_c),
        .done_c_o   (ser_done_c)
    );

    assign InReady   = in_ready_q;
    assign KeyBusy   = busy_q;
    assign Enable    = enable_q;
    assign Encrypt   = encrypt_q;
    assign plainText = pt_q;
    assign key0      = key0_q;
    assign key1      = key1_q;
    assign BlockCnt  = cnt_q;

endmodule

// File: tb/tb_rectangle128_stream_ctrl.sv
// Self-checking bench for rectangle128_stream_ctrl: directed steps plus randomized blocks against a word-level model.
module tb_rectangle128_stream_ctrl;

    localparam int unsigned CNT_W          = 4;
    localparam int unsigned TIMEOUT_CYCLES = 64;

    logic              Clk         = 1'b0;
    logic              Rst         = 1'b1;
    logic [31:0]       InData      = '0;
    logic              InValid     = 1'b0;
    logic              InMode      = 1'b0;
    logic [31:0]       KeyData     = '0;
    logic [1:0]        KeyAddr     = '0;
    logic              KeyWE       = 1'b0;
    logic              OutReady    = 1'b0;
    logic [63:0]       cipherText  = '0;
    logic              cipherReady = 1'b0;
    logic              InReady, KeyBusy, OutValid, Enable, Encrypt, TimeoutErr;
    logic [31:0]       OutData;
    logic [63:0]       plainText, key0, key1;
    logic [CNT_W-1:0]  BlockCnt;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] km [4];
    logic [63:0] pt_m;
    logic [63:0] res_m;
    logic        enc_m;
    int          cnt_m;

    rectangle128_stream_ctrl #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .InData      (InData),
        .InValid     (InValid),
        .InReady     (InReady),
        .InMode      (InMode),
        .KeyData     (KeyData),
        .KeyAddr     (KeyAddr),
        .KeyWE       (KeyWE),
        .KeyBusy     (KeyBusy),
        .OutData     (OutData),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .Enable      (Enable),
        .Encrypt     (Encrypt),
        .plainText   (plainText),
        .key0        (key0),
        .key1        (key1),
        .cipherText  (cipherText),
        .cipherReady (cipherReady),
        .BlockCnt    (BlockCnt),
        .TimeoutErr  (TimeoutErr)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Stand-in for the cipher transform; any mix of all inputs will do.
    function automatic logic [63:0] core_f(input logic [63:0] pt, input logic [63:0] k0,
                                           input logic [63:0] k1, input logic enc);
        return enc ? ((pt ^ k0) + k1) : ((pt - k1) ^ k0);
    endfunction

    function automatic logic [63:0] mk0();
        return {km[0], km[1]};
    endfunction

    function automatic logic [63:0] mk1();
        return {km[2], km[3]};
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"},   64'(InReady),    64'(1));
        chk({tag, "_out_valid"},  64'(OutValid),   64'(0));
        chk({tag, "_out_data"},   64'(OutData),    64'(0));
        chk({tag, "_enable"},     64'(Enable),     64'(0));
        chk({tag, "_encrypt"},    64'(Encrypt),    64'(0));
        chk({tag, "_plaintext"},  plainText,       64'(0));
        chk({tag, "_key0"},       key0,            64'(0));
        chk({tag, "_key1"},       key1,            64'(0));
        chk({tag, "_block_cnt"},  64'(BlockCnt),   64'(0));
        chk({tag, "_timeout"},    64'(TimeoutErr), 64'(0));
        chk({tag, "_key_busy"},   64'(KeyBusy),    64'(0));
    endtask

    task automatic key_write(input logic [1:0] a, input logic [31:0] d);
        KeyWE   = 1'b1;
        KeyAddr = a;
        KeyData = d;
        step();
        KeyWE   = 1'b0;
        km[a]   = d;
    endtask

    task automatic send_block(input logic [31:0] hi, input logic [31:0] lo, input logic mode,
                              input bit kw, input logic [1:0] ka, input logic [31:0] kd);
        chk("idle_in_ready", 64'(InReady), 64'(1));
        InValid = 1'b1;
        InData  = hi;
        InMode  = mode;
        if (kw) begin
            KeyWE   = 1'b1;
            KeyAddr = ka;
            KeyData = kd;
        end
        step();
        KeyWE = 1'b0;
        if (kw) km[ka] = kd;
        pt_m[63:32] = hi;
        enc_m       = mode;
        chk("load_lo_in_ready", 64'(InReady), 64'(1));
        InData = lo;
        InMode = ~mode;
        step();
        InValid    = 1'b0;
        pt_m[31:0] = lo;
        chk("run_enable_rise", 64'(Enable),  64'(1));
        chk("run_plaintext",   plainText,    pt_m);
        chk("run_encrypt",     64'(Encrypt), 64'(enc_m));
        chk("run_key0",        key0,         mk0());
        chk("run_key1",        key1,         mk1());
        chk("run_key_busy",    64'(KeyBusy), 64'(1));
    endtask

    task automatic run_core(input int lat, input bit fixed, input logic [63:0] ct_fixed, input bit busy_kw);
        int steps;
        steps = lat - 1;
        if (busy_kw) begin
            KeyWE   = 1'b1;
            KeyAddr = 2'd0;
            KeyData = 32'hFFFF_FFFF;
            step();
            KeyWE = 1'b0;
            steps--;
            chk("busy_key0_unchanged", key0,         mk0());
            chk("busy_flag",           64'(KeyBusy), 64'(1));
        end
        for (int i = 0; i < steps; i++) step();
        chk("run_enable_held",  64'(Enable),  64'(1));
        chk("run_pt_stable",    plainText,    pt_m);
        chk("run_in_ready_low", 64'(InReady), 64'(0));
        cipherReady = 1'b1;
        cipherText  = fixed ? ct_fixed : core_f(plainText, key0, key1, Encrypt);
        step();
        cipherReady = 1'b0;
        cipherText  = {$urandom, $urandom};
        res_m = fixed ? ct_fixed : core_f(pt_m, mk0(), mk1(), enc_m);
        chk("enable_drop",    64'(Enable),   64'(0));
        chk("out_valid_rise", 64'(OutValid), 64'(1));
        chk("out_hi_first",   64'(OutData),  64'(res_m[63:32]));
    endtask

    task automatic drain(input int hold, input int p_ready);
        logic [31:0] words [2];
        int idx;
        int budget;
        words[0] = res_m[63:32];
        words[1] = res_m[31:0];
        idx      = 0;
        budget   = 400;
        OutReady = 1'b0;
        for (int i = 0; i < hold; i++) begin
            cipherReady = 1'b1;
            cipherText  = {$urandom, $urandom};
            step();
            chk("hold_valid",    64'(OutValid), 64'(1));
            chk("hold_data",     64'(OutData),  64'(words[0]));
            chk("hold_in_ready", 64'(InReady),  64'(0));
        end
        cipherReady = 1'b0;
        while (idx < 2 && budget > 0) begin
            OutReady = ($urandom_range(99) < p_ready);
            chk("out_valid", 64'(OutValid), 64'(1));
            chk("out_data",  64'(OutData),  64'(words[idx]));
            if (OutReady) idx++;
            step();
            budget--;
        end
        chk("drain_words", 64'(idx), 64'(2));
        OutReady = 1'b0;
        cnt_m++;
        chk("out_valid_fall", 64'(OutValid), 64'(0));
        chk("block_cnt",      64'(BlockCnt), 64'(cnt_m % (1 << CNT_W)));
        chk("back_in_ready",  64'(InReady),  64'(1));
        chk("back_not_busy",  64'(KeyBusy),  64'(0));
    endtask

    initial begin
        int nk;
        int gap;
        for (int i = 0; i < 4; i++) km[i] = '0;
        cnt_m = 0;
        pt_m  = '0;
        res_m = '0;
        enc_m = 1'b0;

        step();
        step();
        chk_reset("por");
        Rst = 1'b0;
        step();

        // Core handshake outside RUN must be ignored.
        cipherReady = 1'b1;
        cipherText  = {$urandom, $urandom};
        step();
        cipherReady = 1'b0;
        step();
        chk("idle_crdy_valid", 64'(OutValid), 64'(0));
        chk("idle_crdy_ready", 64'(InReady),  64'(1));
        chk("idle_crdy_busy",  64'(KeyBusy),  64'(0));

        key_write(2'd0, 32'h0011_2233);
        key_write(2'd1, 32'h4455_6677);
        key_write(2'd2, 32'h8899_AABB);
        key_write(2'd3, 32'hCCDD_EEFF);
        send_block(32'h0123_4567, 32'h89AB_CDEF, 1'b1, 1'b0, 2'd0, 32'h0);
        chk("dir_key0",      key0,      64'h0011_2233_4455_6677);
        chk("dir_key1",      key1,      64'h8899_AABB_CCDD_EEFF);
        chk("dir_plaintext", plainText, 64'h0123_4567_89AB_CDEF);
        run_core(26, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 1'b1);
        drain(10, 100);

        // Key write and first-word handshake in the same IDLE cycle.
        send_block($urandom, $urandom, 1'b0, 1'b1, 2'd3, 32'h1357_9BDF);
        chk("kw_same_cycle", 64'(key1[31:0]), 64'h1357_9BDF);
        run_core(int'($urandom_range(30, 1)), 1'b0, 64'h0, 1'b0);
        drain(0, 70);

        send_block($urandom, $urandom, 1'b1, 1'b0, 2'd0, 32'h0);
`ifdef RECT128_TIMEOUT_EN
        for (int i = 0; i < int'(TIMEOUT_CYCLES) - 1; i++) step();
        chk("wdog_pending_err",    64'(TimeoutErr), 64'(0));
        chk("wdog_pending_enable", 64'(Enable),     64'(1));
        step();
        chk("wdog_err",       64'(TimeoutErr), 64'(1));
        chk("wdog_enable",    64'(Enable),     64'(0));
        chk("wdog_idle",      64'(InReady),    64'(1));
        chk("wdog_busy",      64'(KeyBusy),    64'(0));
        chk("wdog_no_output", 64'(OutValid),   64'(0));
        chk("wdog_cnt",       64'(BlockCnt),   64'(cnt_m % (1 << CNT_W)));
        send_block($urandom, $urandom, 1'b0, 1'b0, 2'd0, 32'h0);
        run_core(5, 1'b0, 64'h0, 1'b0);
        drain(0, 100);
        chk("wdog_sticky", 64'(TimeoutErr), 64'(1));
`else
        run_core(120, 1'b0, 64'h0, 1'b0);
        chk("no_wdog_err", 64'(TimeoutErr), 64'(0));
        drain(0, 100);
`endif

        // Reset pulse in the middle of RUN.
        send_block($urandom, $urandom, 1'b1, 1'b0, 2'd0, 32'h0);
        for (int i = 0; i < 5; i++) step();
        #2;
        Rst = 1'b1;
        #1;
        chk_reset("mid_run");
        step();
        Rst = 1'b0;
        for (int i = 0; i < 4; i++) km[i] = '0;
        cnt_m = 0;
        step();

        for (int b = 0; b < 18; b++) begin
            nk = int'($urandom_range(3, 0));
            for (int k = 0; k < nk; k++) key_write(2'($urandom_range(3, 0)), $urandom);
            gap = int'($urandom_range(2, 0));
            for (int g = 0; g < gap; g++) step();
            send_block($urandom, $urandom, 1'($urandom_range(1, 0)), 1'b0, 2'd0, 32'h0);
            run_core(int'($urandom_range(40, 1)), 1'b0, 64'h0, 1'b0);
            drain(int'($urandom_range(3, 0)), int'($urandom_range(100, 40)));
        end
        chk("final_timeout_err", 64'(TimeoutErr), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rectangle128_stream_ctrl.md
# rectangle128_stream_ctrl

- Upstream front-end for the RECTANGLE-128 cipher top.
- Accepts 32-bit plaintext/ciphertext words and 32-bit key words over valid/ready streams.
- Packs words into 64-bit blocks and drives the cipher's `Enable`/`Encrypt`/`plainText`/`key0`/`key1` inputs.
- Captures `cipherText` on `cipherReady` and returns the result as two 32-bit words on an output valid/ready stream.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: watchdog limit in RUN (used only with `RECT128_TIMEOUT_EN`).
- `CNT_W`, default 16: width of the completed-block counter.

Ports:
- `Clk` in 1: single clock, rising edge.
- `Rst` in 1: reset, asynchronous, active-high.
- `InData` in 32: plaintext word.
- `InValid` in 1: word present.
- `InReady` out 1: word accepted when `InValid && InReady`.
- `InMode` in 1: 1 = encrypt, 0 = decrypt; sampled with the first word of a block.
- `KeyData` in 32: key word.
- `KeyAddr` in 2: 0 = key0[63:32], 1 = key0[31:0], 2 = key1[63:32], 3 = key1[31:0].
- `KeyWE` in 1: key write strobe; honoured only in IDLE.
- `KeyBusy` out 1: 1 whenever state ≠ IDLE.
- `OutData` out 32: result word.
- `OutValid` out 1: result word present.
- `OutReady` in 1: downstream accepts the word.
- `Enable` out 1: to cipher.
- `Encrypt` out 1: to cipher.
- `plainText` out 64: to cipher.
- `key0` out 64: to cipher.
- `key1` out 64: to cipher.
- `cipherText` in 64: from cipher.
- `cipherReady` in 1: from cipher.
- `BlockCnt` out CNT_W: completed blocks.
- `TimeoutErr` out 1: sticky watchdog flag.

## Operation
- States: IDLE, LOAD_LO, RUN, OUT_HI, OUT_LO.
- IDLE:
  - `InReady`=1.
  - Word accepted → `plainText[63:32]`, `InMode` → `Encrypt`, go to LOAD_LO.
  - `KeyWE` writes the addressed key half-word.
- LOAD_LO:
  - `InReady`=1.
  - Word accepted → `plainText[31:0]`, go to RUN.
- RUN:
  - `Enable`=1, `InReady`=0; `plainText`, `Encrypt`, `key0` and `key1` held stable.
  - `cipherReady` sampled 1 → `cipherText` captured into the result register, go to OUT_HI.
- OUT_HI:
  - `OutValid`=1, `OutData`=result[63:32].
  - `OutReady` → go to OUT_LO.
- OUT_LO:
  - `OutValid`=1, `OutData`=result[31:0].
  - `OutReady` → `BlockCnt`+1 (wraps from all-ones to 0), go to IDLE.
- `Enable` is 1 only in RUN. It drops in the cycle after `cipherReady` is sampled, which restarts the cipher cleanly for the next block.
- `KeyWE` outside IDLE is ignored; `KeyBusy` tells the writer.
- `KeyWE` and an `InData` handshake in the same IDLE cycle:
  - Both take effect.
  - The key write lands before RUN, so it applies to this block.
- `cipherReady` outside RUN is ignored.
- `OutValid` stays asserted and `OutData` stays stable until `OutReady`; no word is dropped or repeated.

## Timing
- Reset (async, immediate) values:
  - State = IDLE; `InReady`=1.
  - `OutValid`=0, `OutData`=0.
  - `Enable`=0, `Encrypt`=0.
  - `plainText`=0, `key0`=0, `key1`=0.
  - `BlockCnt`=0, `TimeoutErr`=0, `KeyBusy`=0.
- Reset asserted mid-operation:
  - The block in flight is abandoned.
  - `Enable` falls asynchronously.
  - Keys are cleared.
- Second input handshake at edge N → `Enable`=1 from cycle N+1.
- `cipherReady` sampled at edge M → `OutValid`=1 with the high word from cycle M+1; `Enable`=0 in cycle M+1.
- With `OutReady` held at 1, the output takes 2 cycles.
- Minimum spacing: back-to-back blocks with `OutReady`=1 need 2 + core latency + 2 cycles.
- All outputs are registered. `OutValid` and `InReady` are not combinationally dependent on `OutReady` or `InValid`.

## Configuration
- `RECT128_TIMEOUT_EN` defined:
  - A counter clears on RUN entry and counts RUN cycles.
  - Reaching `TIMEOUT_CYCLES` with no `cipherReady` sets `TimeoutErr` (sticky until `Rst`), drops `Enable` and returns to IDLE.
  - No output is produced and `BlockCnt` is unchanged.
- `RECT128_TIMEOUT_EN` undefined:
  - No counter; RUN waits indefinitely.
  - `TimeoutErr` is tied to 0.

## Structure
- Shared package `rectangle128_pkg` holds:
  - The state enum.
  - Block width 64, word width 32 and key-address constants.
- Sub-module `rectangle128_out_ser`:
  - 64-bit capture register plus a 2-word valid/ready serializer (OUT_HI/OUT_LO handling).
  - The main FSM hands it a load strobe and waits for its done.

## Test plan
- **Key then block:**
  - Stimulus: keys 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF written to addresses 0–3; then words 0x01234567, 0x89ABCDEF with `InMode`=1.
  - Response: `key0`=0x0011223344556677, `key1`=0x8899AABBCCDDEEFF, `plainText`=0x0123456789ABCDEF, `Encrypt`=1, `Enable`=1 the cycle after the second handshake.
- **Result serialization:**
  - Stimulus: core model raises `cipherReady` 26 cycles into RUN with `cipherText`=0xDEADBEEFCAFEF00D.
  - Response: `OutData` 0xDEADBEEF then 0xCAFEF00D, `BlockCnt`=1, `Enable`=0 the cycle after `cipherReady`.
- **Output backpressure:**
  - Stimulus: `OutReady`=0 for 10 cycles.
  - Response: 0xDEADBEEF held stable with `OutValid`=1, `InReady`=0; no data loss after release.
- **Key write while busy:**
  - Stimulus: `KeyWE` at address 0 with 0xFFFFFFFF during RUN.
  - Response: `key0` unchanged, `KeyBusy`=1.
- **Reset mid-RUN:**
  - Stimulus: `Rst` pulsed during RUN.
  - Response: `Enable`=0 immediately, all outputs at reset values, next block processes normally.
- **Timeout (`RECT128_TIMEOUT_EN`, `TIMEOUT_CYCLES`=64):**
  - Stimulus: `cipherReady` never asserted.
  - Response: `TimeoutErr`=1 after 64 RUN cycles, IDLE, `BlockCnt` unchanged.
